alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port round-robin arbiter and sequencer that shares a single `ALU_DESIGN` instance between two independent requesters. Each requester presents one operation (operands, command, mode, carry-in, operand-valid) through a valid/ready handshake. The block issues the granted operation to the ALU, holds its inputs stable for the ALU's fixed latency and captures the registered flags and result. It then returns them tagged with the requester ID. It sits between the request sources and the ALU datapath, and it owns `CE` and all ALU operand inputs.

## Interface
- `WIDTH`, 8: operand width; ALU result is `2*WIDTH`.
- `CMD_W`, 4: command field width.
- `ALU_LAT`, 2: cycles from ALU input sample (`CE`=1) to valid `RES`/flags; legal range 1–7.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-requester request valid.
- `req_ready` out 2: per-requester accept; at most one bit high.
- `req_opa`, `req_opb` in 2×WIDTH: per-requester operands.
- `req_cmd` in 2×CMD_W; `req_mode`, `req_cin` in 2×1; `req_inp_valid` in 2×2: per-requester operation fields.
- `alu_opa`, `alu_opb` out WIDTH; `alu_cmd` out CMD_W; `alu_mode`, `alu_cin`, `alu_ce` out 1; `alu_inp_valid` out 2: drive the ALU.
- `alu_res` in 2*WIDTH; `alu_g`, `alu_l`, `alu_e`, `alu_err`, `alu_cout`, `alu_oflow` in 1: ALU outputs.
- `rsp_valid` out 1; `rsp_ready` in 1; `rsp_id` out 1: response handshake and tag.
- `rsp_res` out 2*WIDTH; `rsp_flags` out 6: `{g,l,e,err,cout,oflow}`.
- `err_cnt` out 16: saturating ALU error count (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One operation is in flight at a time.
- IDLE: the grant is computed combinationally from `req_valid` and the priority pointer. `req_ready[g]`=1 only for the granted requester. On `req_valid[g] & req_ready[g]`, the block latches that requester's fields and ID, flips the pointer to the other requester, and moves to ISSUE.
- Round-robin: the requester granted last has lowest priority. With a single requester active, it is granted on every IDLE.
- ISSUE: drives the latched fields onto `alu_*`, `alu_ce`=1, and loads the wait counter with `ALU_LAT-1`. Goes to WAIT, or goes straight to capture if `ALU_LAT`=1.
- WAIT: holds `alu_*` inputs and `alu_ce`=1 stable and decrements the counter. When the counter reaches 0, the block captures `alu_res` and the flags into the response registers on that edge and moves to RESP.
- RESP: `rsp_valid`=1, and the response fields stay stable until `rsp_ready`. On handshake, the block goes to IDLE. `alu_ce`=0 and the ALU inputs are zeroed in IDLE and RESP.
- The arbiter does not check `req_inp_valid`=0; it is passed through, and the ALU's `err` is reported unchanged.
- Requests are never dropped. A deasserted `req_valid` while waiting for a grant is legal; a requester must hold its fields stable while `req_valid`=1.

## Timing
- Reset values: `req_ready`=0, all `alu_*`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_res`=0, `rsp_flags`=0, `err_cnt`=0. State returns to IDLE and the priority pointer to requester 0.
- Accept at edge N, so ISSUE occupies cycle N+1. The result is captured at edge N+1+ALU_LAT, and `rsp_valid` goes high in the following cycle.
- With `rsp_ready` held at 1, back-to-back throughput is one operation per `ALU_LAT+3` cycles.
- `RST` during ISSUE, WAIT or RESP abandons the operation: `rsp_valid` and `alu_ce` are 0 in the next cycle and no response is emitted.
- If both requesters raise `req_valid` in the same cycle, the pointer decides the grant.
- `rsp_ready` high while `rsp_valid` is low is ignored.

## Configuration
- `ALU_ARB_ERRCNT_EN` defined: `err_cnt` increments by 1 at each capture with `alu_err`=1 and saturates at 16'hFFFF. It is cleared only by `RST`.
- Not defined: `err_cnt` is tied to 0 and the counter logic is not compiled. All other behaviour is identical.

## Structure
- `alu_pkg` holds the `arb_state_e` enum, the flag bit-index constants (`FLAG_G`…`FLAG_OFLOW`), and the `alu_req_t` struct (opa, opb, cmd, mode, cin, inp_valid).
- One sub-module, `rr_arb2`, contains the two-requester round-robin grant logic and the priority pointer. It has `CLK`/`RST` ports and an `advance` input.

## Test plan
- Requester 0 only, ADD (CMD=0, MODE=1), OPA=8'h0F, OPB=8'h01, CIN=0, ALU_LAT=2 -> `rsp_valid` 4 cycles after accept, `rsp_id`=0, `rsp_res`=16'h0010.
- Both requesters held valid for 4 operations -> grants alternate 0,1,0,1, starting with 0 after reset, and each result matches its own operands.
- `rsp_ready` held low 5 cycles in RESP -> `rsp_*` stable, both `req_ready`=0, and no new ALU issue.
- `RST` asserted during WAIT -> next cycle `alu_ce`=0 and `rsp_valid`=0, pointer at 0, and a later request completes normally.
- With `ALU_ARB_ERRCNT_EN`, 3 ops with `req_inp_valid`=2'b00 -> each response has `rsp_flags[err]`=1 and `err_cnt`=3. Without the macro, `err_cnt`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Struct widths fix the default operand/command widths used by alu_arbiter.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_CMD_W = 4;
  localparam int NUM_FLAGS = 6;

  // Bit positions inside rsp_flags = {g,l,e,err,cout,oflow}
  localparam int FLAG_G     = 5;
  localparam int FLAG_L     = 4;
  localparam int FLAG_E     = 3;
  localparam int FLAG_ERR   = 2;
  localparam int FLAG_COUT  = 1;
  localparam int FLAG_OFLOW = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] opa;
    logic [ALU_WIDTH-1:0] opb;
    logic [ALU_CMD_W-1:0] cmd;
    logic                 mode;
    logic                 cin;
    logic [1:0]           inp_valid;
  } alu_req_t;

  function automatic logic [NUM_FLAGS-1:0] pack_flags(
    input logic g,
    input logic l,
    input logic e,
    input logic err,
    input logic cout,
    input logic oflow
  );
    logic [NUM_FLAGS-1:0] f;
    f = '0;
    f[FLAG_G]     = g;
    f[FLAG_L]     = l;
    f[FLAG_E]     = e;
    f[FLAG_ERR]   = err;
    f[FLAG_COUT]  = cout;
    f[FLAG_OFLOW] = oflow;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle for alu_arbiter.
// slave = arbiter side; master = requesters, ALU and response consumer.
interface alu_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int CMD_W = 4
);

  logic [1:0]                  req_valid;
  logic [1:0]                  req_ready;
  logic [1:0][WIDTH-1:0]       req_opa;
  logic [1:0][WIDTH-1:0]       req_opb;
  logic [1:0][CMD_W-1:0]       req_cmd;
  logic [1:0]                  req_mode;
  logic [1:0]                  req_cin;
  logic [1:0][1:0]             req_inp_valid;

  logic [WIDTH-1:0]            alu_opa;
  logic [WIDTH-1:0]            alu_opb;
  logic [CMD_W-1:0]            alu_cmd;
  logic                        alu_mode;
  logic                        alu_cin;
  logic                        alu_ce;
  logic [1:0]                  alu_inp_valid;
  logic [2*WIDTH-1:0]          alu_res;
  logic                        alu_g;
  logic                        alu_l;
  logic                        alu_e;
  logic                        alu_err;
  logic                        alu_cout;
  logic                        alu_oflow;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_id;
  logic [2*WIDTH-1:0]          rsp_res;
  logic [5:0]                  rsp_flags;
  logic [15:0]                 err_cnt;

  modport slave (
    input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid,
    output req_ready,
    output alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid,
    input  alu_res, alu_g, alu_l, alu_e, alu_err, alu_cout, alu_oflow,
    output rsp_valid, rsp_id, rsp_res, rsp_flags, err_cnt,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin, req_inp_valid,
    input  req_ready,
    input  alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid,
    output alu_res, alu_g, alu_l, alu_e, alu_err, alu_cout, alu_oflow,
    input  rsp_valid, rsp_id, rsp_res, rsp_flags, err_cnt,
    output rsp_ready
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with a one-bit priority pointer.
// The pointer names the preferred requester; it moves past the winner on advance.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (req[ptr_reg]) begin
      grant[ptr_reg] = 1'b1;
    end else if (req[~ptr_reg]) begin
      grant[~ptr_reg] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_reg <= 1'b0;
    end else if (advance) begin
      ptr_reg <= ~grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer that shares one ALU between two requesters, one op in flight.
// Define ALU_ARB_ERRCNT_EN to build the saturating err_cnt; otherwise err_cnt is tied to 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int CMD_W   = ALU_CMD_W,
  parameter int ALU_LAT = 2
) (
  input logic          CLK,
  input logic          RST,
  alu_arbiter_if.slave bus
);

  arb_state_e           state_reg;
  logic [2:0]           cnt_reg;
  logic                 id_reg;
  alu_req_t             alu_op_reg;
  logic                 alu_ce_reg;
  logic                 rsp_valid_reg;
  logic                 rsp_id_reg;
  logic [2*WIDTH-1:0]   rsp_res_reg;
  logic [NUM_FLAGS-1:0] rsp_flags_reg;

  logic [1:0]           grant;
  logic                 gid;
  logic                 accept;
  alu_req_t             req_vec [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_vec[gi] = '{
      opa:       bus.req_opa[gi],
      opb:       bus.req_opb[gi],
      cmd:       bus.req_cmd[gi],
      mode:      bus.req_mode[gi],
      cin:       bus.req_cin[gi],
      inp_valid: bus.req_inp_valid[gi]
    };
  end

  rr_arb2 u_rr (
    .CLK     (CLK),
    .RST     (RST),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign gid           = grant[1];
  assign accept        = (state_reg == ST_IDLE) && !RST && (grant != 2'b00);
  assign bus.req_ready = ((state_reg == ST_IDLE) && !RST) ? grant : 2'b00;

  // ISSUE always hands over to WAIT; with ALU_LAT=1 the counter is already 0
  // there, so capture lands on edge accept+2 exactly as for a direct jump.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      id_reg        <= 1'b0;
      alu_op_reg    <= '0;
      alu_ce_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_res_reg   <= '0;
      rsp_flags_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            alu_op_reg <= req_vec[gid];
            alu_ce_reg <= 1'b1;
            id_reg     <= gid;
            state_reg  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_reg   <= 3'(ALU_LAT - 1);
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg == 3'd0) begin
            rsp_res_reg   <= bus.alu_res;
            rsp_flags_reg <= pack_flags(bus.alu_g, bus.alu_l, bus.alu_e,
                                        bus.alu_err, bus.alu_cout, bus.alu_oflow);
            rsp_id_reg    <= id_reg;
            rsp_valid_reg <= 1'b1;
            alu_ce_reg    <= 1'b0;
            alu_op_reg    <= '0;
            state_reg     <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_opa       = alu_op_reg.opa;
  assign bus.alu_opb       = alu_op_reg.opb;
  assign bus.alu_cmd       = alu_op_reg.cmd;
  assign bus.alu_mode      = alu_op_reg.mode;
  assign bus.alu_cin       = alu_op_reg.cin;
  assign bus.alu_inp_valid = alu_op_reg.inp_valid;
  assign bus.alu_ce        = alu_ce_reg;

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.rsp_res   = rsp_res_reg;
  assign bus.rsp_flags = rsp_flags_reg;

`ifdef ALU_ARB_ERRCNT_EN
  logic [15:0] err_cnt_reg;
  logic        capture;

  assign capture = (state_reg == ST_WAIT) && (cnt_reg == 3'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_reg <= '0;
    end else if (capture && bus.alu_err && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`else
  assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: pipelined ALU model, transaction-level reference
// checked every cycle, plus hand-computed literal expectations.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_arbiter_if #(.WIDTH(W), .CMD_W(CW)) bus ();

  alu_arbiter #(.WIDTH(W), .CMD_W(CW), .ALU_LAT(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] cmd, input logic mode,
                                           input logic cin, input logic [1:0] iv);
    logic [15:0] r;
    logic [5:0]  f;
    r = '0;
    if (mode) begin
      case (cmd)
        4'd0:    r = 16'(a) + 16'(b);
        4'd1:    r = 16'(a) - 16'(b);
        4'd2:    r = 16'(a) + 16'(b) + 16'(cin);
        4'd3:    r = 16'(a) * 16'(b);
        default: r = {a, b};
      endcase
    end else begin
      case (cmd)
        4'd0:    r = {8'h00, a & b};
        4'd1:    r = {8'h00, a | b};
        default: r = {8'h00, a ^ b};
      endcase
    end
    f = '0;
    f[FLAG_G]     = (a > b);
    f[FLAG_L]     = (a < b);
    f[FLAG_E]     = (a == b);
    f[FLAG_ERR]   = (iv != 2'b11);
    f[FLAG_COUT]  = mode & r[8];
    f[FLAG_OFLOW] = 1'b0;
    return {f, r};
  endfunction

  // ALU: samples while CE=1, result appears LAT-1 edges after first sample.
  logic [21:0] alu_pipe [LAT] = '{default: '0};
  always @(posedge CLK) begin
    if (bus.alu_ce)
      alu_pipe[0] <= alu_calc(bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode,
                              bus.alu_cin, bus.alu_inp_valid);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {bus.alu_g, bus.alu_l, bus.alu_e, bus.alu_err, bus.alu_cout, bus.alu_oflow,
          bus.alu_res} = alu_pipe[LAT-1];

  // Reference: an accepted op occupies "age" 1..LAT+1 on the ALU, then waits for the consumer.
  bit          m_armed = 0;
  bit          m_busy  = 0;
  int          m_age   = 0;
  logic        m_last  = 1'b1;
  logic        m_id    = 1'b0;
  logic [7:0]  m_opa, m_opb;
  logic [3:0]  m_cmd;
  logic        m_mode, m_cin;
  logic [1:0]  m_iv;
  logic [15:0] m_res   = '0;
  logic [5:0]  m_flags = '0;
  logic [15:0] m_err   = '0;
  logic        grant_log [$];

  always @(negedge CLK) begin : cmp_proc
    logic [1:0] exp_ready;
    logic       pref;
    bit         ce_exp, rv_exp;
    pref      = ~m_last;
    exp_ready = 2'b00;
    if (!m_busy && !RST) begin
      if (bus.req_valid[pref])       exp_ready[pref]  = 1'b1;
      else if (bus.req_valid[~pref]) exp_ready[~pref] = 1'b1;
    end
    ce_exp = m_busy && (m_age >= 1) && (m_age <= LAT + 1);
    rv_exp = m_busy && (m_age >= LAT + 2);
    if (m_armed) begin
      chk("cyc_req_ready", bus.req_ready, exp_ready);
      chk("cyc_alu_ce", bus.alu_ce, ce_exp);
      chk("cyc_alu_in",
          {bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode, bus.alu_cin, bus.alu_inp_valid},
          ce_exp ? {m_opa, m_opb, m_cmd, m_mode, m_cin, m_iv} : 24'h0);
      chk("cyc_rsp_valid", bus.rsp_valid, rv_exp);
      if (rv_exp) begin
        chk("cyc_rsp_id", bus.rsp_id, m_id);
        chk("cyc_rsp_res", bus.rsp_res, m_res);
        chk("cyc_rsp_flags", bus.rsp_flags, m_flags);
      end
      chk("cyc_err_cnt", bus.err_cnt, m_err);
    end
    if (RST) begin
      m_busy = 0; m_last = 1'b1; m_err = '0; m_armed = 1;
      grant_log.delete();
    end else if (!m_busy) begin
      if (exp_ready != 2'b00) begin
        m_busy = 1; m_age = 1; m_id = exp_ready[1]; m_last = m_id;
        m_opa = bus.req_opa[m_id]; m_opb = bus.req_opb[m_id]; m_cmd = bus.req_cmd[m_id];
        m_mode = bus.req_mode[m_id]; m_cin = bus.req_cin[m_id]; m_iv = bus.req_inp_valid[m_id];
        grant_log.push_back(m_id);
      end
    end else if (rv_exp) begin
      if (bus.rsp_ready) m_busy = 0;
    end else begin
      if (m_age == LAT + 1) begin
        {m_flags, m_res} = alu_calc(m_opa, m_opb, m_cmd, m_mode, m_cin, m_iv);
`ifdef ALU_ARB_ERRCNT_EN
        if (m_flags[FLAG_ERR] && m_err != 16'hFFFF) m_err = m_err + 16'd1;
`endif
      end
      m_age++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] cmd, input logic mode, input logic cin,
                         input logic [1:0] iv);
    bus.req_opa[i] = a; bus.req_opb[i] = b; bus.req_cmd[i] = cmd;
    bus.req_mode[i] = mode; bus.req_cin[i] = cin; bus.req_inp_valid[i] = iv;
  endtask

  task automatic wait_grant(input int i);
    #1;
    for (int k = 0; k < 30; k++) begin
      if (bus.req_ready[i]) break;
      tick();
    end
    chk($sformatf("grant_req%0d", i), bus.req_ready[i], 1'b1);
  endtask

  task automatic wait_rsp(output int cyc, output logic id, output logic [15:0] res,
                          output logic [5:0] fl);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("rsp_arrives", bus.rsp_valid, 1'b1);
    id = bus.rsp_id; res = bus.rsp_res; fl = bus.rsp_flags;
    $display("rsp id=%0d res=0x%04h flags=%06b after %0d cycles", id, res, fl, cyc);
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic one_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] cmd, input logic mode, input logic [1:0] iv,
                        input logic [15:0] exp_res, input logic [5:0] exp_fl, input string tag);
    int          cyc;
    logic        id;
    logic [15:0] res;
    logic [5:0]  fl;
    set_req(i, a, b, cmd, mode, 1'b0, iv);
    bus.req_valid[i] = 1'b1;
    wait_grant(i);
    tick();
    bus.req_valid[i] = 1'b0;
    wait_rsp(cyc, id, res, fl);
    chk({tag, "_id"}, id, i);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_flags"}, fl, exp_fl);
    ack();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          cyc, n;
    logic        id;
    logic [15:0] res;
    logic [5:0]  fl;
    logic        ids [4];
    logic [15:0] ress [4];
    int          rcyc [4];

    bus.req_valid = 2'b11; bus.rsp_ready = 1'b0;
    set_req(0, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 2'b11);
    set_req(1, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 2'b11);
    RST = 1'b1;
    repeat (3) tick();
    chk("reset_req_ready", bus.req_ready, 2'b00);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_id", bus.rsp_id, 1'b0);
    chk("reset_rsp_res", bus.rsp_res, 16'h0000);
    chk("reset_rsp_flags", bus.rsp_flags, 6'h00);
    chk("reset_err_cnt", bus.err_cnt, 16'h0000);
    chk("reset_alu_ce", bus.alu_ce, 1'b0);
    bus.req_valid = 2'b00;
    RST = 1'b0;

    // Single ADD on requester 0: response 4 cycles after the accept cycle
    set_req(0, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11);
    bus.req_valid[0] = 1'b1;
    #1;
    chk("t1_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    wait_rsp(cyc, id, res, fl);
    chk("t1_latency", cyc, 4);
    chk("t1_id", id, 1'b0);
    chk("t1_res", res, 16'h0010);
    chk("t1_flags", fl, 6'b100000);
    ack();

    // Both requesters always valid: grants alternate 0,1,0,1 at LAT+3 spacing
    RST = 1'b1; repeat (2) tick(); RST = 1'b0;
    set_req(0, 8'h20, 8'h05, 4'd1, 1'b1, 1'b0, 2'b11);
    set_req(1, 8'h33, 8'h11, 4'd0, 1'b1, 1'b0, 2'b11);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (bus.rsp_valid) begin
        ids[n] = bus.rsp_id; ress[n] = bus.rsp_res; rcyc[n] = c;
        $display("rr rsp %0d id=%0d res=0x%04h cycle=%0d", n, ids[n], ress[n], c);
        n++;
        if (n == 4) bus.req_valid = 2'b00;
      end
    end
    tick();
    bus.rsp_ready = 1'b0;
    chk("t2_count", n, 4);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("t2_id%0d", i), ids[i], i % 2);
      chk($sformatf("t2_res%0d", i), ress[i], (i % 2) ? 16'h0044 : 16'h001B);
      if (i > 0) chk($sformatf("t2_gap%0d", i), rcyc[i] - rcyc[i-1], LAT + 3);
    end
    chk("t2_model_grants", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      chk($sformatf("t2_model_grant%0d", i), grant_log[i], i % 2);

    // Consumer stalls 5 cycles in RESP while requester 0 is waiting
    set_req(1, 8'h7F, 8'h80, 4'd0, 1'b1, 1'b0, 2'b11);
    bus.req_valid[1] = 1'b1;
    wait_grant(1);
    tick();
    bus.req_valid[1] = 1'b0;
    set_req(0, 8'h0A, 8'h0C, 4'd2, 1'b0, 1'b0, 2'b11);
    bus.req_valid[0] = 1'b1;
    wait_rsp(cyc, id, res, fl);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", bus.rsp_valid, 1'b1);
      chk("t3_hold_id", bus.rsp_id, 1'b1);
      chk("t3_hold_res", bus.rsp_res, 16'h00FF);
      chk("t3_hold_flags", bus.rsp_flags, 6'b010000);
      chk("t3_no_ready", bus.req_ready, 2'b00);
      chk("t3_no_issue", bus.alu_ce, 1'b0);
    end
    ack();
    wait_grant(0);
    tick();
    bus.req_valid[0] = 1'b0;
    wait_rsp(cyc, id, res, fl);
    chk("t3b_id", id, 1'b0);
    chk("t3b_res", res, 16'h0006);
    chk("t3b_flags", fl, 6'b010000);
    ack();

    // Reset during WAIT abandons the op and returns the pointer to requester 0
    set_req(0, 8'h11, 8'h22, 4'd0, 1'b1, 1'b0, 2'b11);
    bus.req_valid[0] = 1'b1;
    wait_grant(0);
    tick();
    bus.req_valid[0] = 1'b0;
    tick();
    chk("t4_in_wait_ce", bus.alu_ce, 1'b1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t4_alu_ce", bus.alu_ce, 1'b0);
    chk("t4_rsp_valid", bus.rsp_valid, 1'b0);
    set_req(0, 8'h03, 8'h04, 4'd3, 1'b1, 1'b0, 2'b11);
    set_req(1, 8'h09, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11);
    bus.req_valid = 2'b11;
    #1;
    chk("t4_ptr0", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(cyc, id, res, fl);
    chk("t4_id", id, 1'b0);
    chk("t4_res", res, 16'h000C);
    chk("t4_flags", fl, 6'b010000);
    ack();

    // Three ops with inp_valid=00: ALU err flag passed through each time
    for (int k = 0; k < 3; k++)
      one_op(0, 8'h05, 8'h05, 4'd0, 1'b1, 2'b00, 16'h000A, 6'b001100, "t5");
`ifdef ALU_ARB_ERRCNT_EN
    chk("t5_err_cnt", bus.err_cnt, 16'd3);
`else
    chk("t5_err_cnt", bus.err_cnt, 16'd0);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
